// File: rtl/pixel_sched_pkg.sv
// Shared types for the pixel update scheduler: FSM state encoding and the
// request payload carried through the request FIFO.
package pixel_sched_pkg;

    localparam int unsigned PIX_COORD_W = 4;
    localparam int unsigned PIX_OBJ_W   = 3;

    typedef enum logic [2:0] {
        INIT_ISSUE = 3'd0,
        INIT_WAIT  = 3'd1,
        IDLE       = 3'd2,
        PIX_ISSUE  = 3'd3,
        PIX_WAIT   = 3'd4,
        CLR_ISSUE  = 3'd5,
        CLR_WAIT   = 3'd6
    } sched_state_t;

    typedef struct packed {
        logic [PIX_COORD_W-1:0] x;
        logic [PIX_COORD_W-1:0] y;
        logic [PIX_OBJ_W-1:0]   obj;
    } pix_req_t;

endpackage

// File: rtl/pixel_req_fifo.sv
// Synchronous request FIFO with push/pop/flush. Flush wins over pop, but a
// push in the flush cycle is kept as the only surviving entry.
module pixel_req_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (flush) begin
            // Everything queued so far is discarded; the write slot becomes the new head.
            rd_ptr_d = wr_ptr_q;
            count_d  = push_ok ? CNT_W'(1) : '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pixel_update_scheduler.sv
// Sequences the pixel updater: one-time init, then single-pixel updates from a
// request FIFO, plus a full-grid clear sweep that takes priority over the FIFO.
module pixel_update_scheduler
    import pixel_sched_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned COORD_W   = PIX_COORD_W,
    parameter int unsigned OBJ_W     = PIX_OBJ_W,
    parameter int unsigned CLEAR_OBJ = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    input  logic [OBJ_W-1:0]   req_obj,
    input  logic               clear_req,
    output logic               upd_init,
    output logic               upd_en,
    output logic [COORD_W-1:0] upd_x,
    output logic [COORD_W-1:0] upd_y,
    output logic [OBJ_W-1:0]   upd_obj,
    input  logic               upd_done,
    output logic               init_done,
    output logic               busy
);

    localparam int unsigned CTR_W = 2 * COORD_W;
    localparam int unsigned REQ_W = $bits(pix_req_t);

    sched_state_t       state_q, state_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic               clear_pend_q, clear_pend_d;
    logic               init_done_q, init_done_d;
    logic               upd_init_q, upd_init_d;
    logic               upd_en_q, upd_en_d;
    logic [COORD_W-1:0] upd_x_q, upd_x_d;
    logic [COORD_W-1:0] upd_y_q, upd_y_d;
    logic [OBJ_W-1:0]   upd_obj_q, upd_obj_d;

    pix_req_t           push_req;
    pix_req_t           head_req;
    logic [REQ_W-1:0]   fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               sweeping;
    logic               clear_hit;

    assign push_req  = '{x: PIX_COORD_W'(req_x), y: PIX_COORD_W'(req_y), obj: PIX_OBJ_W'(req_obj)};
    assign head_req  = fifo_dout;
    assign req_ready = init_done_q && !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign sweeping  = (state_q == CLR_ISSUE) || (state_q == CLR_WAIT);
    assign clear_hit = clear_req && !sweeping;

    pixel_req_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_req),
        .pop   (fifo_pop),
        .flush (clear_hit),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and registered-output logic; upd_en is set on entry to an ISSUE state.
    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        clear_pend_d = clear_pend_q;
        init_done_d  = init_done_q;
        upd_init_d   = 1'b0;
        upd_en_d     = 1'b0;
        upd_x_d      = upd_x_q;
        upd_y_d      = upd_y_q;
        upd_obj_d    = upd_obj_q;
        fifo_pop     = 1'b0;

        if (clear_hit) begin
            clear_pend_d = 1'b1;
        end

        case (state_q)
            INIT_ISSUE: begin
                upd_init_d = 1'b1;
                state_d    = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (upd_done) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (clear_pend_q || clear_hit) begin
                    ctr_d     = '0;
                    upd_x_d   = '0;
                    upd_y_d   = '0;
                    upd_obj_d = OBJ_W'(CLEAR_OBJ);
                    upd_en_d  = 1'b1;
                    state_d   = CLR_ISSUE;
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    upd_x_d   = COORD_W'(head_req.x);
                    upd_y_d   = COORD_W'(head_req.y);
                    upd_obj_d = OBJ_W'(head_req.obj);
                    upd_en_d  = 1'b1;
                    state_d   = PIX_ISSUE;
                end
            end
            PIX_ISSUE: begin
                state_d = PIX_WAIT;
            end
            PIX_WAIT: begin
                if (upd_done) begin
                    state_d = IDLE;
                end
            end
            CLR_ISSUE: begin
                state_d = CLR_WAIT;
            end
            CLR_WAIT: begin
                if (upd_done) begin
                    if (&ctr_q) begin
                        clear_pend_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        // x is the inner index, y the outer.
                        ctr_d     = ctr_q + CTR_W'(1);
                        upd_x_d   = ctr_d[COORD_W-1:0];
                        upd_y_d   = ctr_d[CTR_W-1:COORD_W];
                        upd_obj_d = OBJ_W'(CLEAR_OBJ);
                        upd_en_d  = 1'b1;
                        state_d   = CLR_ISSUE;
                    end
                end
            end
            default: begin
                state_d = INIT_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT_ISSUE;
            ctr_q        <= '0;
            clear_pend_q <= 1'b0;
            init_done_q  <= 1'b0;
            upd_init_q   <= 1'b0;
            upd_en_q     <= 1'b0;
            upd_x_q      <= '0;
            upd_y_q      <= '0;
            upd_obj_q    <= '0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            clear_pend_q <= clear_pend_d;
            init_done_q  <= init_done_d;
            upd_init_q   <= upd_init_d;
            upd_en_q     <= upd_en_d;
            upd_x_q      <= upd_x_d;
            upd_y_q      <= upd_y_d;
            upd_obj_q    <= upd_obj_d;
        end
    end

    assign upd_init  = upd_init_q;
    assign upd_en    = upd_en_q;
    assign upd_x     = upd_x_q;
    assign upd_y     = upd_y_q;
    assign upd_obj   = upd_obj_q;
    assign init_done = init_done_q;
    assign busy      = (state_q != IDLE) || !fifo_empty || clear_pend_q;

endmodule

// File: tb/tb_pixel_update_scheduler.sv
// Directed bench for pixel_update_scheduler: init handshake, single requests,
// FIFO back-pressure and ordering, clear sweeps, flush-on-clear and mid-command reset.
module tb_pixel_update_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_x;
    logic [3:0] req_y;
    logic [2:0] req_obj;
    logic       clear_req;
    logic       upd_init;
    logic       upd_en;
    logic [3:0] upd_x;
    logic [3:0] upd_y;
    logic [2:0] upd_obj;
    logic       upd_done;
    logic       init_done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    pixel_update_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_obj   (req_obj),
        .clear_req (clear_req),
        .upd_init  (upd_init),
        .upd_en    (upd_en),
        .upd_x     (upd_x),
        .upd_y     (upd_y),
        .upd_obj   (upd_obj),
        .upd_done  (upd_done),
        .init_done (init_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_set(input logic [3:0] x, input logic [3:0] y, input logic [2:0] o);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_obj   = o;
    endtask

    task automatic wait_cmd(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                            input logic [2:0] eo);
        for (int n = 0; n < 50 && upd_en !== 1'b1; n++) tick();
        chk({tag, "_en"}, 32'(upd_en), 32'd1);
        chk({tag, "_xyo"}, 32'({upd_x, upd_y, upd_obj}), 32'({ex, ey, eo}));
    endtask

    task automatic done_cmd();
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
    endtask

    task automatic expect_cmd(input string tag, input logic [3:0] ex, input logic [3:0] ey,
                              input logic [2:0] eo);
        wait_cmd(tag, ex, ey, eo);
        tick();
        chk({tag, "_pulse"}, 32'(upd_en), 32'd0);
        chk({tag, "_stable"}, 32'({upd_x, upd_y, upd_obj}), 32'({ex, ey, eo}));
        done_cmd();
    endtask

    task automatic sweep_check(input string tag, input bit mid_clear);
        logic [7:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 8'(i);
            if (mid_clear && i == 100) clear_req = 1'b1;
            expect_cmd(tag, c[3:0], c[7:4], 3'd0);
            clear_req = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_obj   = '0;
        clear_req = 1'b0;
        upd_done  = 1'b0;

        // 1: reset values, init pulse, init_done after upd_done
        tick();
        chk("rst_init", 32'(upd_init), 32'd0);
        chk("rst_en", 32'(upd_en), 32'd0);
        chk("rst_xyo", 32'({upd_x, upd_y, upd_obj}), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("init_pulse", 32'(upd_init), 32'd1);
        tick();
        chk("init_pulse_end", 32'(upd_init), 32'd0);
        tick();
        chk("init_single", 32'(upd_init), 32'd0);
        chk("init_not_done", 32'(init_done), 32'd0);
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
        chk("init_done", 32'(init_done), 32'd1);
        chk("init_ready", 32'(req_ready), 32'd1);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_no_repeat", 32'(upd_init), 32'd0);

        // 2: single request (3,5,2)
        push_set(4'd3, 4'd5, 3'd2);
        tick();
        req_valid = 1'b0;
        chk("px_not_yet", 32'(upd_en), 32'd0);
        chk("px_busy", 32'(busy), 32'd1);
        tick();
        chk("px_en_latency", 32'(upd_en), 32'd1);
        expect_cmd("px", 4'd3, 4'd5, 3'd2);
        chk("px_idle_busy", 32'(busy), 32'd0);

        // 3: back-pressure with one command outstanding, then ordered drain
        push_set(4'd12, 4'd3, 3'd6);
        tick();
        req_valid = 1'b0;
        wait_cmd("bp_r0", 4'd12, 4'd3, 3'd6);
        for (int i = 1; i <= 8; i++) begin
            push_set(4'(i), 4'(15 - i), 3'(i));
            chk("bp_ready", 32'(req_ready), 32'd1);
            tick();
        end
        push_set(4'd9, 4'd6, 3'd1);
        chk("bp_full", 32'(req_ready), 32'd0);
        done_cmd();
        chk("bp_still_full", 32'(req_ready), 32'd0);
        for (int n = 0; n < 10 && req_ready !== 1'b1; n++) tick();
        chk("bp_slot_free", 32'(req_ready), 32'd1);
        chk("bp_r1_en", 32'(upd_en), 32'd1);
        chk("bp_r1_xyo", 32'({upd_x, upd_y, upd_obj}), 32'({4'd1, 4'd14, 3'd1}));
        tick();
        req_valid = 1'b0;
        chk("bp_r1_stable", 32'({upd_x, upd_y, upd_obj}), 32'({4'd1, 4'd14, 3'd1}));
        done_cmd();
        for (int i = 2; i <= 9; i++) begin
            expect_cmd("bp_drain", 4'(i), 4'(15 - i), 3'(i));
        end
        chk("bp_empty_busy", 32'(busy), 32'd0);

        // 4: full sweep with a clear_req mid-sweep that must not restart it
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        sweep_check("clr", 1'b1);
        tick();
        tick();
        chk("clr_no_restart", 32'(upd_en), 32'd0);
        chk("clr_done_busy", 32'(busy), 32'd0);

        // 5: clear flushes queued entries but keeps the same-cycle push
        push_set(4'd1, 4'd1, 3'd1);
        tick();
        req_valid = 1'b0;
        wait_cmd("fl_s0", 4'd1, 4'd1, 3'd1);
        for (int i = 0; i < 4; i++) begin
            push_set(4'(i + 10), 4'(i), 3'd3);
            chk("fl_ready", 32'(req_ready), 32'd1);
            tick();
        end
        push_set(4'd7, 4'd7, 3'd1);
        clear_req = 1'b1;
        tick();
        req_valid = 1'b0;
        clear_req = 1'b0;
        chk("fl_busy", 32'(busy), 32'd1);
        chk("fl_s0_held", 32'({upd_x, upd_y, upd_obj}), 32'({4'd1, 4'd1, 3'd1}));
        done_cmd();
        sweep_check("fl_clr", 1'b0);
        expect_cmd("fl_kept", 4'd7, 4'd7, 3'd1);
        tick();
        tick();
        chk("fl_no_more", 32'(upd_en), 32'd0);
        chk("fl_idle_busy", 32'(busy), 32'd0);

        // 6: reset during PIX_WAIT aborts and replays init
        push_set(4'd2, 4'd3, 3'd4);
        tick();
        req_valid = 1'b0;
        wait_cmd("rw", 4'd2, 4'd3, 3'd4);
        tick();
        rst = 1'b1;
        tick();
        chk("rw_en", 32'(upd_en), 32'd0);
        chk("rw_init", 32'(upd_init), 32'd0);
        chk("rw_xyo", 32'({upd_x, upd_y, upd_obj}), 32'd0);
        chk("rw_init_done", 32'(init_done), 32'd0);
        chk("rw_busy", 32'(busy), 32'd1);
        chk("rw_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("rw_reinit", 32'(upd_init), 32'd1);
        tick();
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
        chk("rw_init_done2", 32'(init_done), 32'd1);
        chk("rw_idle_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
